// File: rtl/led_flash_multi.sv
// led_flash_multi: N_CH independent button-to-LED flash channels.
// Each channel synchronises and debounces an active-low button. A press starts
// either a burst of FLASH_COUNT on/off cycles or a continuous blink, depending
// on i_MODE as sampled at the press.
//
// Ports:
//   i_SCLK  - system clock, all state changes on the rising edge
//   i_RESET - asynchronous active-high reset
//   i_BTN   - raw buttons, active-low, one bit per channel
//   i_MODE  - 0 = burst, 1 = continuous blink (latched per channel at press)
//   o_LED   - registered LED drive, 1 = lit (only while in ON)
//   o_BUSY  - registered, 1 while the channel FSM is not idle
//   o_DONE  - one-clock pulse when a burst completes normally
module led_flash_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEB_CYCLES  = 3,
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic            i_SCLK,
    input  logic            i_RESET,
    input  logic [N_CH-1:0] i_BTN,
    input  logic            i_MODE,
    output logic [N_CH-1:0] o_LED,
    output logic [N_CH-1:0] o_BUSY,
    output logic [N_CH-1:0] o_DONE
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned PH_W  = $clog2(HALF_PERIOD) + 1;
    localparam int unsigned FL_W  = $clog2(FLASH_COUNT) + 1;

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             deb_q, deb_prev_q, press_q;
        logic [DEB_W-1:0] deb_cnt_q;
        state_e           state_q, state_d;
        logic [PH_W-1:0]  phase_q, phase_d;
        logic [FL_W-1:0]  flash_q, flash_d;
        logic             mode_q, mode_d;
        logic             led_d, busy_d, done_d;
        logic             led_q, busy_q, done_q;

        // Synchroniser, debouncer and press-edge detector.
        always_ff @(posedge i_SCLK or posedge i_RESET) begin
            if (i_RESET) begin
                sync1_q    <= 1'b1;
                sync2_q    <= 1'b1;
                deb_q      <= 1'b1;
                deb_prev_q <= 1'b1;
                press_q    <= 1'b0;
                deb_cnt_q  <= '0;
            end else begin
                sync1_q    <= i_BTN[g];
                sync2_q    <= sync1_q;
                deb_prev_q <= deb_q;
                // Registered one-clock pulse on a debounced 1->0 transition.
                press_q    <= deb_prev_q & ~deb_q;
                if (sync2_q != deb_q) begin
                    if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                        deb_q     <= sync2_q;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_q <= '0;
                end
            end
        end

        // FSM state register plus registered outputs.
        always_ff @(posedge i_SCLK or posedge i_RESET) begin
            if (i_RESET) begin
                state_q <= StIdle;
                phase_q <= '0;
                flash_q <= '0;
                mode_q  <= 1'b0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                flash_q <= flash_d;
                mode_q  <= mode_d;
                led_q   <= led_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
            end
        end

        // Next-state logic.
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            flash_d = flash_q;
            mode_d  = mode_q;
            unique case (state_q)
                StIdle: begin
                    if (press_q) begin
                        state_d = StOn;
                        mode_d  = i_MODE;
                        flash_d = FL_W'(FLASH_COUNT);
                        phase_d = '0;
                    end
                end
                StOn, StOff: begin
                    // Only a continuous-mode channel reacts to a press while busy.
                    if (press_q && mode_q) begin
                        state_d = StIdle;
                        phase_d = '0;
                    end else if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                        phase_d = '0;
                        if (state_q == StOn) begin
                            state_d = StOff;
                        end else if (mode_q) begin
                            state_d = StOn;
                        end else begin
                            flash_d = flash_q - FL_W'(1);
                            state_d = (flash_q != FL_W'(1)) ? StOn : StIdle;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Output decode; a burst-mode OFF->IDLE move is always a normal completion.
        always_comb begin
            led_d  = (state_d == StOn);
            busy_d = (state_d != StIdle);
            done_d = (state_q == StOff) && (state_d == StIdle) && !mode_q;
        end

        assign o_LED[g]  = led_q;
        assign o_BUSY[g] = busy_q;
        assign o_DONE[g] = done_q;
    end

endmodule

// File: tb/tb_led_flash_multi.sv
// Scoreboard bench for led_flash_multi at default parameters. The stimulus
// process pushes the expected outputs for every cycle into a queue; a monitor
// on the falling edge pops and compares them.
module tb_led_flash_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic         mode;
    logic [N-1:0] led, busy, done;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int           cyc;
        string        name;
        logic [N-1:0] led;
        logic [N-1:0] busy;
        logic [N-1:0] done;
    } chk_t;

    chk_t q[$];

    led_flash_multi #(
        .N_CH(4),
        .DEB_CYCLES(3),
        .HALF_PERIOD(4),
        .FLASH_COUNT(3)
    ) dut (
        .i_SCLK (clk),
        .i_RESET(rst),
        .i_BTN  (btn),
        .i_MODE (mode),
        .o_LED  (led),
        .o_BUSY (busy),
        .o_DONE (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due at this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                n_tests++;
                if (q[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cyc=%0d not made in time (now %0d)",
                             q[i].name, q[i].cyc, cyc);
                end else if (led !== q[i].led || busy !== q[i].busy ||
                             done !== q[i].done) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got led=%b busy=%b done=%b, need led=%b busy=%b done=%b",
                             q[i].name, cyc, led, busy, done, q[i].led, q[i].busy, q[i].done);
                end
                q.delete(i);
            end
        end
    end

    // Hand-derived burst waveform, rel = cycles since the first edge sampling low.
    // LED rises after edge 6, three 4-on/4-off cycles, DONE after edge 30.
    function automatic logic [2:0] burst(input int rel);
        logic on, act;
        act = (rel >= 6) && (rel < 30);
        on  = act && (((rel - 6) % 8) < 4);
        return {on, act, rel == 30};
    endfunction

    // Continuous blink that is stopped at edge 'stop'.
    function automatic logic [2:0] cont(input int rel, input int stop);
        logic on, act;
        act = (rel >= 6) && (rel < stop);
        on  = act && (((rel - 6) % 8) < 4);
        return {on, act, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input string name, input logic [N-1:0] l, input logic [N-1:0] b,
                        input logic [N-1:0] d);
        chk_t c;
        c.cyc  = cyc;
        c.name = name;
        c.led  = l;
        c.busy = b;
        c.done = d;
        q.push_back(c);
    endtask

    task automatic idle(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            step();
            push(name, '0, '0, '0);
        end
    endtask

    initial begin
        int           p, p2, rel, e;
        logic [2:0]   b, b3;
        logic [N-1:0] el, eb, ed;

        rst  = 1'b1;
        btn  = '1;
        mode = 1'b0;
        idle(3, "reset");
        rst = 1'b0;
        idle(5, "post_reset");

        // Burst on ch0 held 13 clocks; a 2-clock glitch on ch1 must be ignored.
        step();
        p = cyc + 1;
        for (int k = 0; k < 40; k++) begin
            rel = cyc - p;
            b   = burst(rel);
            push("burst_ch0_glitch_ch1", {3'b0, b[2]}, {3'b0, b[1]}, {3'b0, b[0]});
            e      = cyc + 1 - p;
            btn[0] = !(e >= 0 && e < 13);
            btn[1] = !(e >= 0 && e < 2);
            step();
        end
        btn = '1;
        idle(10, "gap_a");

        // Burst on ch0 with a second press landing in the second ON phase.
        step();
        p = cyc + 1;
        for (int k = 0; k < 38; k++) begin
            rel = cyc - p;
            b   = burst(rel);
            push("burst_ignore_press", {3'b0, b[2]}, {3'b0, b[1]}, {3'b0, b[0]});
            e      = cyc + 1 - p;
            btn[0] = !((e >= 0 && e < 5) || (e >= 10 && e < 21));
            step();
        end
        btn = '1;
        idle(10, "gap_b");

        // Continuous blink on ch2, stopped by a second press (FSM sees it at edge 64).
        mode = 1'b1;
        step();
        p = cyc + 1;
        for (int k = 0; k < 76; k++) begin
            rel = cyc - p;
            b   = cont(rel, 64);
            el  = '0;
            eb  = '0;
            el[2] = b[2];
            eb[2] = b[1];
            push("continuous_ch2", el, eb, '0);
            e      = cyc + 1 - p;
            btn[2] = !((e >= 0 && e < 5) || (e >= 58 && e < 63));
            step();
        end
        btn  = '1;
        mode = 1'b0;
        idle(10, "gap_c");

        // ch0 and ch3 pressed together in burst mode; i_MODE flips mid-burst.
        step();
        p = cyc + 1;
        for (int k = 0; k < 38; k++) begin
            rel = cyc - p;
            b   = burst(rel);
            push("dual_burst_mode_flip", {b[2], 2'b0, b[2]}, {b[1], 2'b0, b[1]},
                 {b[0], 2'b0, b[0]});
            e      = cyc + 1 - p;
            btn[0] = !(e >= 0 && e < 5);
            btn[3] = !(e >= 0 && e < 5);
            mode   = (rel >= 9);
            step();
        end
        btn  = '1;
        mode = 1'b0;
        idle(10, "gap_d");

        // Reset during the first OFF of a burst; the held button re-flashes.
        step();
        p  = cyc + 1;
        p2 = p + 14;
        for (int k = 0; k < 62; k++) begin
            rel = cyc - p;
            if (rel < 11)      b3 = burst(rel);
            else if (rel < 14) b3 = 3'b000;
            else               b3 = burst(cyc - p2);
            push("reset_mid_burst", {3'b0, b3[2]}, {3'b0, b3[1]}, {3'b0, b3[0]});
            if (rel == 11) rst = 1'b1;
            if (rel == 13) rst = 1'b0;
            e      = cyc + 1 - p;
            btn[0] = !(e >= 0 && e < 54);
            step();
        end
        btn = '1;
        idle(10, "tail");

        step();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d checks never made, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
